leaf_user_stream_bridge: RTL and testbench
==========================================

// Module: leaf_user_stream_bridge
// PURPOSE
//  User-side terminator of one leaf_interface input/output lane pair, in the clk_user domain.
//  Accepts words from the interface vld/ack stream into an RX FIFO and presents them to an HLS kernel as ap_fifo read.
//  Takes kernel ap_fifo writes into a TX FIFO and drives them back to the interface as a vld/ack stream.
//  Instantiated per lane pair inside user kernels placed in leaf shells.
// PARAMETERS
//  PAYLOAD_BITS  32  word width, equals leaf_interface PAYLOAD_BITS
//  FIFO_DEPTH    4   entries per FIFO; power of two, >= 2
//  CNT_BITS      16  width of the transfer counters
// PORTS
//  clk_user                  in   1             user clock, single clock domain
//  reset                     in   1             synchronous, active-high
//  dout_leaf_interface2user  in   PAYLOAD_BITS  RX data from interface
//  vld_interface2user        in   1             RX valid
//  ack_user2interface        out  1             RX ready (space in RX FIFO)
//  din_leaf_user2interface   out  PAYLOAD_BITS  TX data to interface
//  vld_user2interface        out  1             TX valid
//  ack_interface2user        in   1             TX ready from interface
//  in_dout                   out  PAYLOAD_BITS  kernel read data (head of RX FIFO)
//  in_empty_n                out  1             RX FIFO non-empty
//  in_read                   in   1             kernel pops RX head
//  out_din                   in   PAYLOAD_BITS  kernel write data
//  out_full_n                out  1             TX FIFO not full
//  out_write                 in   1             kernel pushes out_din
//  rx_count                  out  CNT_BITS      words accepted from interface
//  tx_count                  out  CNT_BITS      words delivered to interface
// BEHAVIOUR
//  - Transfer rule, both streams: word moves on a rising clk_user edge where vld && ack are both 1; no other condition.
//  - vld, once asserted, holds with stable data until accepted (TX side guarantees; RX side relies on it).
//  - Reset: all pointers/occupancy/counters to 0. While reset=1: ack_user2interface=0, vld_user2interface=0,
//    in_empty_n=0, out_full_n=0, in_dout/din_leaf_user2interface=0. First cycle after reset: ack=1, out_full_n=1.
//  - Reset mid-operation discards all FIFO contents; in-flight words are lost, no partial handshake survives.
//  - RX: ack_user2interface = !rx_full (combinational from registered occupancy). Push on vld&&ack.
//    First-word fall-through: pushed word visible on in_dout with in_empty_n=1 the cycle after push (latency 1).
//    in_read with in_empty_n=0 is ignored. Pop on in_read && in_empty_n.
//  - RX full + in_read same cycle: no push that cycle (ack=0); ack rises next cycle.
//  - RX empty + push same cycle as in_read: read ignored, word available next cycle.
//  - TX: out_full_n = !tx_full. Push on out_write && out_full_n; out_write while full is dropped (kernel error).
//    vld_user2interface = !tx_empty, din_leaf_user2interface = TX head; pop on vld&&ack_interface2user. Latency 1.
//  - Simultaneous push and pop on a non-empty, non-full FIFO: occupancy unchanged, order preserved.
//  - Pointers are log2(FIFO_DEPTH) bits, wrap naturally; occupancy is log2(FIFO_DEPTH)+1 bits, full = (occ==FIFO_DEPTH).
//  - rx_count/tx_count increment by 1 per transfer, wrap modulo 2^CNT_BITS, no saturation.
//  - No state machine beyond FIFO occupancy; throughput 1 word/cycle each direction when unblocked.
// STRUCTURE
//  - leaf_pkg: PAYLOAD_BITS default constant shared with leaf_interface; clog2 helper.
//  - Sub-module sync_fifo_fwft (params WIDTH, DEPTH; ports wr_en/din/full, rd_en/dout/empty, reset),
//    instantiated twice (rx_fifo, tx_fifo). Handshake mapping and counters live in the top.
// TESTING
//  1. Reset then idle -> ack_user2interface=1, out_full_n=1, in_empty_n=0, vld_user2interface=0, counters 0.
//  2. Push 0x11,0x22,0x33 on consecutive RX cycles, in_read held 1 -> in_dout 0x11,0x22,0x33 in order, rx_count=3.
//  3. RX push 5 words with in_read=0, DEPTH=4 -> ack drops after 4th, 5th held; one in_read -> 5th accepted next cycle.
//  4. Kernel writes 0xA0..0xA3, ack_interface2user=0 -> out_full_n=0; raise ack -> 4 words out in order, tx_count=4.
//  5. TX random ack/write backpressure 1000 words -> scoreboard exact order, no loss, no duplicates.
//  6. Assert reset with 2 words in each FIFO -> next cycle all outputs at reset values, following traffic starts clean.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared constants for leaf shells and user-side bridges.
//   LEAF_PAYLOAD_BITS : default payload width of one leaf_interface lane
//   clog2             : ceiling log2 helper for sizing pointers
package leaf_pkg;

  localparam int unsigned LEAF_PAYLOAD_BITS = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
//   clk   : clock
//   reset : synchronous active-high; clears pointers and occupancy
//   wr_en : push request, ignored while full
//   din   : push data
//   full  : occupancy == DEPTH
//   rd_en : pop request, ignored while empty
//   dout  : head entry (0 while empty)
//   empty : occupancy == 0
module sync_fifo_fwft
  import leaf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   OccOne = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   OccFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q;
  logic             do_wr, do_rd;

  assign full  = (occ_q == OccFull);
  assign empty = (occ_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_wr && !do_rd) begin
        occ_q <= occ_q + OccOne;
      end else if (do_rd && !do_wr) begin
        occ_q <= occ_q - OccOne;
      end
    end
  end

endmodule

// File: rtl/leaf_user_stream_bridge.sv
// User-side terminator of one leaf_interface lane pair (clk_user domain).
//   RX: interface vld/ack stream -> rx_fifo -> kernel ap_fifo read (in_*)
//   TX: kernel ap_fifo write (out_*) -> tx_fifo -> interface vld/ack stream
//   rx_count / tx_count : wrapping counts of words accepted / delivered
// All handshake outputs are forced inactive (and data to 0) while reset is high.
module leaf_user_stream_bridge
  import leaf_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_BITS     = 16
) (
  input  logic                    clk_user,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
  input  logic                    vld_interface2user,
  output logic                    ack_user2interface,
  output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
  output logic                    vld_user2interface,
  input  logic                    ack_interface2user,
  output logic [PAYLOAD_BITS-1:0] in_dout,
  output logic                    in_empty_n,
  input  logic                    in_read,
  input  logic [PAYLOAD_BITS-1:0] out_din,
  output logic                    out_full_n,
  input  logic                    out_write,
  output logic [CNT_BITS-1:0]     rx_count,
  output logic [CNT_BITS-1:0]     tx_count
);

  localparam logic [CNT_BITS-1:0] CntOne = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic                    rx_full, rx_empty, rx_push, rx_pop;
  logic                    tx_full, tx_empty, tx_push, tx_pop;
  logic [PAYLOAD_BITS-1:0] rx_head, tx_head;
  logic [CNT_BITS-1:0]     rx_count_q, tx_count_q;

  // RX handshake: ack depends only on registered occupancy, never on vld.
  assign ack_user2interface = !reset && !rx_full;
  assign rx_push            = vld_interface2user && ack_user2interface;
  assign in_empty_n         = !reset && !rx_empty;
  assign rx_pop             = in_read && in_empty_n;
  assign in_dout            = reset ? '0 : rx_head;

  // TX handshake.
  assign out_full_n              = !reset && !tx_full;
  assign tx_push                 = out_write && out_full_n;
  assign vld_user2interface      = !reset && !tx_empty;
  assign tx_pop                  = vld_user2interface && ack_interface2user;
  assign din_leaf_user2interface = reset ? '0 : tx_head;

  sync_fifo_fwft #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) rx_fifo (
    .clk   (clk_user),
    .reset (reset),
    .wr_en (rx_push),
    .din   (dout_leaf_interface2user),
    .full  (rx_full),
    .rd_en (rx_pop),
    .dout  (rx_head),
    .empty (rx_empty)
  );

  sync_fifo_fwft #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) tx_fifo (
    .clk   (clk_user),
    .reset (reset),
    .wr_en (tx_push),
    .din   (out_din),
    .full  (tx_full),
    .rd_en (tx_pop),
    .dout  (tx_head),
    .empty (tx_empty)
  );

  always_ff @(posedge clk_user) begin
    if (reset) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      if (rx_push) rx_count_q <= rx_count_q + CntOne;
      if (tx_pop)  tx_count_q <= tx_count_q + CntOne;
    end
  end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_leaf_user_stream_bridge.sv
module tb_leaf_user_stream_bridge;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [31:0] dout_leaf_interface2user;
  logic        vld_interface2user;
  logic        ack_user2interface;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [31:0] in_dout;
  logic        in_empty_n;
  logic        in_read;
  logic [31:0] out_din;
  logic        out_full_n;
  logic        out_write;
  logic [15:0] rx_count;
  logic [15:0] tx_count;

  int checks = 0;
  int errors = 0;

  always #5 clk_user = ~clk_user;

  leaf_user_stream_bridge dut (
    .clk_user                 (clk_user),
    .reset                    (reset),
    .dout_leaf_interface2user (dout_leaf_interface2user),
    .vld_interface2user       (vld_interface2user),
    .ack_user2interface       (ack_user2interface),
    .din_leaf_user2interface  (din_leaf_user2interface),
    .vld_user2interface       (vld_user2interface),
    .ack_interface2user       (ack_interface2user),
    .in_dout                  (in_dout),
    .in_empty_n               (in_empty_n),
    .in_read                  (in_read),
    .out_din                  (out_din),
    .out_full_n               (out_full_n),
    .out_write                (out_write),
    .rx_count                 (rx_count),
    .tx_count                 (tx_count)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_user);
    #1;
  endtask

  task automatic idle_inputs();
    vld_interface2user       = 1'b0;
    dout_leaf_interface2user = '0;
    ack_interface2user       = 1'b0;
    in_read                  = 1'b0;
    out_write                = 1'b0;
    out_din                  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    checks++; if (ack_user2interface !== 1'b0) begin errors++;
      $display("FAIL reset_ack_in_reset: got %b expected 0", ack_user2interface); end
    checks++; if (out_full_n !== 1'b0) begin errors++;
      $display("FAIL reset_full_n_in_reset: got %b expected 0", out_full_n); end
    reset = 1'b0;
    #1;
    checks++; if (ack_user2interface !== 1'b1) begin errors++;
      $display("FAIL reset_ack: got %b expected 1", ack_user2interface); end
    checks++; if (out_full_n !== 1'b1) begin errors++;
      $display("FAIL reset_out_full_n: got %b expected 1", out_full_n); end
    checks++; if (in_empty_n !== 1'b0) begin errors++;
      $display("FAIL reset_in_empty_n: got %b expected 0", in_empty_n); end
    checks++; if (vld_user2interface !== 1'b0) begin errors++;
      $display("FAIL reset_vld: got %b expected 0", vld_user2interface); end
    checks++; if (rx_count !== 16'd0 || tx_count !== 16'd0) begin errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
  endtask

  task automatic test_rx_stream();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    in_read = 1'b1;
    vld_interface2user = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dout_leaf_interface2user = words[i];
      step();
      checks++; if (in_empty_n !== 1'b1 || in_dout !== words[i]) begin errors++;
        $display("FAIL rx_stream_word%0d: got %h (empty_n %b) expected %h", i, in_dout,
                 in_empty_n, words[i]); end
    end
    vld_interface2user = 1'b0;
    step();
    in_read = 1'b0;
    checks++; if (in_empty_n !== 1'b0) begin errors++;
      $display("FAIL rx_stream_drained: got empty_n %b expected 0", in_empty_n); end
    checks++; if (rx_count !== 16'd3) begin errors++;
      $display("FAIL rx_stream_count: got %0d expected 3", rx_count); end
  endtask

  task automatic test_rx_full();
    in_read = 1'b0;
    vld_interface2user = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dout_leaf_interface2user = 32'h50 + i;
      checks++; if (ack_user2interface !== 1'b1) begin errors++;
        $display("FAIL rx_full_ack_before%0d: got %b expected 1", i, ack_user2interface); end
      step();
    end
    dout_leaf_interface2user = 32'h54;
    checks++; if (ack_user2interface !== 1'b0) begin errors++;
      $display("FAIL rx_full_ack_full: got %b expected 0", ack_user2interface); end
    step();
    checks++; if (rx_count !== 16'd7) begin errors++;
      $display("FAIL rx_full_count_held: got %0d expected 7", rx_count); end
    // Pop while full: no push this cycle, ack rises next cycle.
    in_read = 1'b1;
    step();
    in_read = 1'b0;
    checks++; if (ack_user2interface !== 1'b1) begin errors++;
      $display("FAIL rx_full_ack_after_pop: got %b expected 1", ack_user2interface); end
    checks++; if (rx_count !== 16'd7) begin errors++;
      $display("FAIL rx_full_no_push_on_pop: got %0d expected 7", rx_count); end
    step();
    vld_interface2user = 1'b0;
    checks++; if (rx_count !== 16'd8) begin errors++;
      $display("FAIL rx_full_fifth_accepted: got %0d expected 8", rx_count); end
    in_read = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++; if (in_empty_n !== 1'b1 || in_dout !== 32'h50 + i) begin errors++;
        $display("FAIL rx_full_drain%0d: got %h expected %h", i, in_dout, 32'h50 + i); end
      step();
    end
    in_read = 1'b0;
    checks++; if (in_empty_n !== 1'b0) begin errors++;
      $display("FAIL rx_full_empty: got %b expected 0", in_empty_n); end
  endtask

  task automatic test_tx_fill();
    ack_interface2user = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_full_n !== 1'b1) begin errors++;
        $display("FAIL tx_fill_full_n%0d: got %b expected 1", i, out_full_n); end
      out_write = 1'b1;
      out_din   = 32'hA0 + i;
      step();
    end
    out_write = 1'b0;
    checks++; if (out_full_n !== 1'b0) begin errors++;
      $display("FAIL tx_fill_full: got %b expected 0", out_full_n); end
    // Write while full must be dropped.
    out_write = 1'b1;
    out_din   = 32'hEE;
    step();
    out_write = 1'b0;
    ack_interface2user = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (vld_user2interface !== 1'b1 || din_leaf_user2interface !== 32'hA0 + i)
      begin errors++;
        $display("FAIL tx_fill_out%0d: got %h (vld %b) expected %h", i,
                 din_leaf_user2interface, vld_user2interface, 32'hA0 + i); end
      step();
    end
    ack_interface2user = 1'b0;
    checks++; if (vld_user2interface !== 1'b0) begin errors++;
      $display("FAIL tx_fill_drained: got vld %b expected 0", vld_user2interface); end
    checks++; if (tx_count !== 16'd4) begin errors++;
      $display("FAIL tx_fill_count: got %0d expected 4", tx_count); end
  endtask

  task automatic test_tx_random();
    logic [31:0] sb [$];
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    while (recv < 1000 && cycles < 20000) begin
      out_write = (sent < 1000) && ($urandom_range(0, 3) != 0);
      out_din   = 32'hC000_0000 + sent;
      ack_interface2user = ($urandom_range(0, 2) != 0);
      #1;
      if (out_write && out_full_n) begin
        sb.push_back(out_din);
        sent++;
      end
      if (vld_user2interface && ack_interface2user) begin
        logic [31:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        checks++; if (din_leaf_user2interface !== exp) begin errors++;
          $display("FAIL tx_random_word%0d: got %h expected %h", recv,
                   din_leaf_user2interface, exp); end
        recv++;
      end
      step();
      cycles++;
    end
    out_write = 1'b0;
    ack_interface2user = 1'b0;
    checks++; if (recv != 1000) begin errors++;
      $display("FAIL tx_random_timeout: got %0d words expected 1000", recv); end
    checks++; if (tx_count !== 16'd1004) begin errors++;
      $display("FAIL tx_random_count: got %0d expected 1004", tx_count); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    vld_interface2user = 1'b1;
    out_write = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dout_leaf_interface2user = 32'h60 + i;
      out_din = 32'h70 + i;
      step();
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if ({ack_user2interface, vld_user2interface, in_empty_n, out_full_n} !== 4'b0)
    begin errors++;
      $display("FAIL reset_mid_flags: got %b expected 0000",
               {ack_user2interface, vld_user2interface, in_empty_n, out_full_n}); end
    checks++; if (in_dout !== 32'd0 || din_leaf_user2interface !== 32'd0) begin errors++;
      $display("FAIL reset_mid_data: got %h/%h expected 0/0", in_dout,
               din_leaf_user2interface); end
    step();
    reset = 1'b0;
    #1;
    checks++; if ({ack_user2interface, out_full_n, in_empty_n, vld_user2interface} !== 4'b1100)
    begin errors++;
      $display("FAIL reset_mid_after: got %b expected 1100",
               {ack_user2interface, out_full_n, in_empty_n, vld_user2interface}); end
    checks++; if (rx_count !== 16'd0 || tx_count !== 16'd0) begin errors++;
      $display("FAIL reset_mid_counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
    vld_interface2user = 1'b1;
    dout_leaf_interface2user = 32'h77;
    out_write = 1'b1;
    out_din = 32'h88;
    step();
    idle_inputs();
    checks++; if (in_empty_n !== 1'b1 || in_dout !== 32'h77 || rx_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_mid_rx_clean: got %h cnt %0d expected 77 cnt 1", in_dout,
               rx_count); end
    checks++; if (vld_user2interface !== 1'b1 || din_leaf_user2interface !== 32'h88) begin
      errors++;
      $display("FAIL reset_mid_tx_clean: got %h expected 88", din_leaf_user2interface); end
    ack_interface2user = 1'b1;
    step();
    ack_interface2user = 1'b0;
    checks++; if (tx_count !== 16'd1 || vld_user2interface !== 1'b0) begin errors++;
      $display("FAIL reset_mid_tx_count: got %0d expected 1", tx_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_rx_stream();
    test_rx_full();
    test_tx_fill();
    test_tx_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
